ssu_sck_gen: RTL and testbench

//  Master-mode bit-rate and frame sequencer for the SSU serial port.

---
 rtl/ssu_sck_gen.sv | 152 +++++++++++++++
 tb/tb_ssu_sck_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssu_sck_gen.sv
// rtl/ssu_sck_gen.sv - SSU master-mode serial clock and frame sequencer
module ssu_sck_gen #(
  parameter int BITS  = 8,
  parameter int CKS_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    ms,
  input  logic [CKS_W-1:0]        cks,
  input  logic                    cpol,
  input  logic                    cpha,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    ssck_out,
  output logic                    ssck_oe,
  output logic                    scs_out,
  output logic                    scs_oe,
  output logic                    shift_stb,
  output logic                    sample_stb,
  output logic [$clog2(BITS)-1:0] bit_idx
);

  localparam int IDX_W  = $clog2(BITS);
  localparam int EDGE_W = $clog2(2 * BITS);
  localparam int DIV_W  = 7;
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * BITS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt, div_nxt, half_m1;
  logic [EDGE_W-1:0] edge_cnt, edge_nxt;
  logic [CKS_W-1:0]  cks_l;
  logic              cpol_l, cpha_l;
  logic [31:0]       cks_eff;
  logic              tick;
  logic              accept;
  logic              busy_nxt, done_nxt, ssck_nxt, scs_nxt, oe_q, oe_nxt;
  logic              shift_nxt, sample_nxt;
  logic [IDX_W-1:0]  bit_nxt;

  assign ssck_oe = oe_q;
  assign scs_oe  = oe_q;
  assign tick    = (div_cnt == half_m1);
  assign accept  = (state == IDLE) && start && en;

  // Half period minus one from the latched clock select; selects above 6 alias to 6.
  always_comb begin
    cks_eff = 32'(cks_l);
    if (cks_eff > 32'd6) cks_eff = 32'd6;
    half_m1 = DIV_W'((32'd2 << cks_eff) - 32'd1);
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_nxt  = state;
    div_nxt    = div_cnt + 1'b1;
    edge_nxt   = edge_cnt;
    ssck_nxt   = ssck_out;
    shift_nxt  = 1'b0;
    sample_nxt = 1'b0;
    bit_nxt    = bit_idx;

    case (state)
      IDLE:    if (start) state_nxt = LEAD;
      LEAD:    if (tick) state_nxt = XFER;
      XFER:    if (tick && (edge_cnt == LAST_EDGE)) state_nxt = TRAIL;
      TRAIL:   if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!en) state_nxt = IDLE;

    if (tick || (state_nxt != state) || (state == IDLE)) div_nxt = '0;

    if (state_nxt != XFER) edge_nxt = '0;
    else if ((state == XFER) && tick) edge_nxt = edge_cnt + 1'b1;

    if ((state_nxt == IDLE) || (state == IDLE)) ssck_nxt = cpol;
    else if (state_nxt == TRAIL) ssck_nxt = cpol_l;
    else if ((state == XFER) && tick) ssck_nxt = ~ssck_out;

    // Even edge count is the leading edge of a bit cell.
    if (en && (state == XFER) && tick) begin
      if (cpha_l) begin
        shift_nxt  = ~edge_cnt[0];
        sample_nxt = edge_cnt[0];
      end else begin
        sample_nxt = ~edge_cnt[0];
        shift_nxt  = edge_cnt[0] && (edge_cnt != LAST_EDGE);
      end
    end

    if (!en) bit_nxt = '0;
    else if (sample_stb) bit_nxt = (bit_idx == IDX_LAST) ? '0 : bit_idx + 1'b1;

    busy_nxt = (state_nxt != IDLE);
    scs_nxt  = (state_nxt == IDLE);
    done_nxt = en && (state == TRAIL) && tick;
    oe_nxt   = en && ms;
  end

  // State, divider and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      edge_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ssck_out   <= 1'b0;
      scs_out    <= 1'b1;
      oe_q       <= 1'b0;
      shift_stb  <= 1'b0;
      sample_stb <= 1'b0;
      bit_idx    <= '0;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_nxt;
      edge_cnt   <= edge_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      ssck_out   <= ssck_nxt;
      scs_out    <= scs_nxt;
      oe_q       <= oe_nxt;
      shift_stb  <= shift_nxt;
      sample_stb <= sample_nxt;
      bit_idx    <= bit_nxt;
    end
  end

  // Frame configuration is frozen when a start is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      cks_l  <= '0;
      cpol_l <= 1'b0;
      cpha_l <= 1'b0;
    end else if (accept) begin
      cks_l  <= cks;
      cpol_l <= cpol;
      cpha_l <= cpha;
    end
  end

endmodule

// File: tb/tb_ssu_sck_gen.sv
// tb/tb_ssu_sck_gen.sv - scoreboard bench for ssu_sck_gen
module tb_ssu_sck_gen;

  localparam int BITS  = 8;
  localparam int CKS_W = 3;
  localparam int K_BUSY = 0, K_SCS = 1, K_EDGE = 2, K_SHIFT = 3, K_SAMPLE = 4, K_DONE = 5;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  logic clk = 1'b0;
  logic rst, en, ms, cpol, cpha, start;
  logic [CKS_W-1:0] cks;
  logic busy, done, ssck_out, ssck_oe, scs_out, scs_oe, shift_stb, sample_stb;
  logic [$clog2(BITS)-1:0] bit_idx;

  ev_t exp_q[$];
  int  cyc = 0;
  bit  rst_s = 1'b0;
  bit  oe_s = 1'b0;
  bit  fin = 1'b0;
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  model_lvl = 1'b0;
  bit  p_busy = 1'b0, p_scs = 1'b1, p_ssck = 1'b0;

  ssu_sck_gen #(.BITS(BITS), .CKS_W(CKS_W)) dut (
    .clk(clk), .rst(rst), .en(en), .ms(ms), .cks(cks), .cpol(cpol), .cpha(cpha),
    .start(start), .busy(busy), .done(done), .ssck_out(ssck_out), .ssck_oe(ssck_oe),
    .scs_out(scs_out), .scs_oe(scs_oe), .shift_stb(shift_stb), .sample_stb(sample_stb),
    .bit_idx(bit_idx)
  );

  always #5 clk = ~clk;

  // cycle counter plus the inputs the DUT saw at this edge
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      rst_s = rst;
      oe_s = en & ms;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d required=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input int val);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event cyc=%0d got kind=%0d val=%0d required no event", cyc, kind, val);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != cyc || e.kind != kind || e.val != val) begin
        n_bad++;
        $display("FAIL event got cyc=%0d kind=%0d val=%0d required cyc=%0d kind=%0d val=%0d",
                 cyc, kind, val, e.cyc, e.kind, e.val);
      end
    end
  endtask

  // monitor: turns DUT activity into events and checks them against the queue
  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        if (rst_s) begin
          chk("rst_busy", busy, 0);
          chk("rst_done", done, 0);
          chk("rst_ssck", ssck_out, 0);
          chk("rst_scs", scs_out, 1);
          chk("rst_oe", {ssck_oe, scs_oe}, 0);
          chk("rst_stb", {shift_stb, sample_stb}, 0);
          chk("rst_bit_idx", bit_idx, 0);
        end else begin
          chk("ssck_oe", ssck_oe, oe_s);
          chk("scs_oe", scs_oe, oe_s);
          if (busy != p_busy) begin
            expect_ev(K_BUSY, busy);
            if (!busy) chk("bit_idx_end", bit_idx, 0);
          end
          if (scs_out != p_scs) expect_ev(K_SCS, scs_out);
          if (ssck_out != p_ssck) expect_ev(K_EDGE, ssck_out);
          if (shift_stb) expect_ev(K_SHIFT, 0);
          if (sample_stb) expect_ev(K_SAMPLE, bit_idx);
          if (done) expect_ev(K_DONE, 0);
        end
        p_busy = busy;
        p_scs = scs_out;
        p_ssck = ssck_out;
      end
      if (fin || cyc > 90000) break;
    end
    if (!fin) begin
      n_cmp++;
      n_bad++;
      $display("FAIL watchdog got cyc=%0d required stimulus end", cyc);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_events got %0d left required 0 (next cyc=%0d kind=%0d)",
               exp_q.size(), exp_q[0].cyc, exp_q[0].kind);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input int k, input int v);
    ev_t e;
    e.cyc = c;
    e.kind = k;
    e.val = v;
    exp_q.push_back(e);
  endtask

  // idle-only: ssck follows the live polarity one cycle later
  task automatic set_cpol(input bit v);
    cpol = v;
    if (v != model_lvl) push(cyc + 1, K_EDGE, int'(v));
    model_lvl = v;
    step();
  endtask

  // reference frame: edge j lands at s+1+(j+2)*H, frame ends at s+1+(2*BITS+2)*H
  task automatic start_frame(input int k, input bit ph, input int abort_off, input bit disturb);
    int s, h, e_cyc, a, t, n_before, stop;
    bit p, lead;
    p = model_lvl;
    s = cyc;
    h = 2 << ((k > 6) ? 6 : k);
    e_cyc = s + 1 + (2 * BITS + 2) * h;
    a = (abort_off > 0) ? s + abort_off : 0;
    n_before = 0;
    push(s + 1, K_BUSY, 1);
    push(s + 1, K_SCS, 0);
    for (int j = 0; j < 2 * BITS; j++) begin
      t = s + 1 + (j + 2) * h;
      if (a == 0 || t <= a) begin
        n_before++;
        lead = ((j % 2) == 0);
        push(t, K_EDGE, int'(p ^ lead));
        if (!ph) begin
          if (lead) push(t, K_SAMPLE, j / 2);
          else if (j != 2 * BITS - 1) push(t, K_SHIFT, 0);
        end else begin
          if (lead) push(t, K_SHIFT, 0);
          else push(t, K_SAMPLE, j / 2);
        end
      end
    end
    if (a == 0) begin
      push(e_cyc, K_BUSY, 0);
      push(e_cyc, K_SCS, 1);
      push(e_cyc, K_DONE, 0);
      stop = e_cyc;
    end else begin
      push(a + 1, K_BUSY, 0);
      push(a + 1, K_SCS, 1);
      if ((n_before % 2) == 1) push(a + 1, K_EDGE, int'(p));
      stop = a + 1;
    end
    cks = CKS_W'(k);
    cpha = ph;
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < stop) begin
      if (disturb && cyc == s + 10) begin
        start = 1'b1;
        cks = CKS_W'($urandom);
        cpol = ~p;
      end
      if (disturb && cyc == s + 11) start = 1'b0;
      if (disturb && cyc == s + 20) begin
        cpol = p;
        cks = CKS_W'(k);
      end
      if (a != 0 && cyc == a) en = 1'b0;
      step();
    end
    en = 1'b1;
  endtask

  // stimulus
  initial begin
    int k, ab;
    bit dis, b2b;
    rst = 1'b1; en = 1'b0; ms = 1'b1; cks = '0; cpol = 1'b1; cpha = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    en = 1'b1;
    push(cyc + 1, K_EDGE, 1);
    model_lvl = 1'b1;
    step(); step();

    set_cpol(1'b0); step();
    start_frame(0, 1'b0, 0, 1'b0);
    step(); step();

    set_cpol(1'b1); step();
    start_frame(2, 1'b1, 0, 1'b0);
    step();

    start_frame(7, 1'b0, 0, 1'b0);
    step();
    start_frame(6, 1'b1, 0, 1'b0);
    step();

    set_cpol(1'b0); step();
    start_frame(0, 1'b0, 20, 1'b0);
    step(); step();

    start_frame(0, 1'b0, 0, 1'b1);
    step();

    start_frame(1, 1'b0, 0, 1'b0);
    start_frame(1, 1'b1, 0, 1'b0);
    step();

    en = 1'b0; start = 1'b1;
    step();
    start = 1'b0; en = 1'b1;
    step(); step();

    ms = 1'b0;
    start_frame(0, 1'b1, 0, 1'b0);
    ms = 1'b1;
    step();

    b2b = 1'b0;
    for (int i = 0; i < 30; i++) begin
      ms = ($urandom_range(0, 3) != 0);
      if (!b2b) begin
        set_cpol(1'($urandom_range(0, 1)));
        repeat ($urandom_range(0, 3)) step();
      end
      k = $urandom_range(0, 3);
      ab = 0;
      dis = 1'b0;
      case ($urandom_range(0, 4))
        0: ab = $urandom_range(1, (2 * BITS + 2) * (2 << k) - 1);
        1: dis = 1'b1;
        default: ;
      endcase
      start_frame(k, 1'($urandom_range(0, 1)), ab, dis);
      b2b = (ab == 0) && ($urandom_range(0, 2) == 0);
    end

    repeat (3) step();
    fin = 1'b1;
  end

endmodule
